// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL dynamic-phase sequencer.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    IDLE,
    SETUP,
    PULSE,
    GAP,
    DONE
  } state_t;

  localparam logic OP_STEP   = 1'b0;
  localparam logic OP_RELOAD = 1'b1;

  localparam logic [1:0] OUT_CLKOP  = 2'd0;
  localparam logic [1:0] OUT_CLKOS  = 2'd1;
  localparam logic [1:0] OUT_CLKOS2 = 2'd2;
  localparam logic [1:0] OUT_CLKOS3 = 2'd3;

  localparam int TMR_W = 16;

endpackage

// File: rtl/pll_lock_qual.sv
// Synchronises the PLL LOCK and qualifies it with a consecutive-high stability count.
module pll_lock_qual #(
  parameter int LOCK_CYC = 1024
) (
  input  logic clk_i,
  input  logic reset_n,
  input  logic pll_locked,
  output logic lock_ok
);

  localparam int CNT_W = $clog2(LOCK_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_CYC);

  logic             lock_p0;
  logic             lock_p1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      lock_p0 <= 1'b0;
      lock_p1 <= 1'b0;
      cnt     <= '0;
    end else begin
      lock_p0 <= pll_locked;
      lock_p1 <= lock_p0;
      if (!lock_p1)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
    end
  end

  // Gating with lock_p1 drops lock_ok in the very cycle the synchronised lock goes low.
  assign lock_ok = lock_p1 && (cnt == CNT_MAX);

endmodule

// File: rtl/pll_phase_ctrl.sv
// Turns host phase-adjust requests into timed PHASESEL/DIR/STEP/LOADREG activity
// and tracks the accumulated step position of each PLL output.
module pll_phase_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 4,
  parameter int LOCK_CYC  = 1024,
  parameter int STEP_W    = 8,
  parameter int POS_W     = 10
) (
  input  logic                clk_i,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_op,
  input  logic [1:0]          req_sel,
  input  logic                req_dir,
  input  logic [STEP_W-1:0]   req_steps,
  input  logic                pll_locked,
  output logic [1:0]          phasesel,
  output logic                phasedir,
  output logic                phasestep,
  output logic                phaseloadreg,
  output logic                lock_ok,
  output logic                busy,
  output logic                done,
  output logic                err_lock,
  input  logic                err_clr,
  output logic [4*POS_W-1:0]  pos_o
);

  localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'(SETUP_CYC - 1);
  localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(GAP_CYC - 1);

  state_t            state;
  logic              op_q;
  logic [STEP_W-1:0] rem;
  logic [TMR_W-1:0]  tmr;
  logic [POS_W-1:0]  pos [4];

  function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] p, input logic retard);
    return retard ? p - 1'b1 : p + 1'b1;
  endfunction

  pll_lock_qual #(.LOCK_CYC(LOCK_CYC)) u_lock_qual (
    .clk_i      (clk_i),
    .reset_n    (reset_n),
    .pll_locked (pll_locked),
    .lock_ok    (lock_ok)
  );

  assign req_ready = lock_ok && (state == IDLE);

  for (genvar g = 0; g < 4; g++) begin : g_pos
    assign pos_o[g*POS_W +: POS_W] = pos[g];
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state        <= WAIT_LOCK;
      op_q         <= OP_STEP;
      rem          <= '0;
      tmr          <= '0;
      phasesel     <= OUT_CLKOP;
      phasedir     <= 1'b0;
      phasestep    <= 1'b0;
      phaseloadreg <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_lock     <= 1'b0;
      for (int i = 0; i < 4; i++) pos[i] <= '0;
    end else begin
      done <= 1'b0;
      if (err_clr) err_lock <= 1'b0;
      case (state)
        WAIT_LOCK: if (lock_ok) state <= IDLE;
        IDLE: begin
          if (!lock_ok) begin
            state <= WAIT_LOCK;
          end else if (req_valid) begin
            op_q     <= req_op;
            rem      <= req_steps;
            phasesel <= req_sel;
            phasedir <= req_dir;
            tmr      <= '0;
            busy     <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP, PULSE, GAP: begin
          if (!lock_ok) begin
            // Abort: remaining steps are discarded, counted positions stay.
            phasestep    <= 1'b0;
            phaseloadreg <= 1'b0;
            busy         <= 1'b0;
            err_lock     <= 1'b1;
            state        <= WAIT_LOCK;
          end else begin
            tmr <= tmr + 1'b1;
            case (state)
              SETUP: if (tmr == SETUP_LAST) begin
                tmr <= '0;
                if (op_q == OP_STEP && rem == '0) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= DONE;
                end else begin
                  phasestep    <= (op_q == OP_STEP);
                  phaseloadreg <= (op_q == OP_RELOAD);
                  state        <= PULSE;
                end
              end
              PULSE: if (tmr == PULSE_LAST) begin
                tmr          <= '0;
                phasestep    <= 1'b0;
                phaseloadreg <= 1'b0;
                state        <= GAP;
                if (op_q == OP_STEP) begin
                  pos[phasesel] <= step_pos(pos[phasesel], phasedir);
                  rem           <= rem - 1'b1;
                end else begin
                  pos[phasesel] <= '0;
                end
              end
              GAP: if (tmr == GAP_LAST) begin
                tmr <= '0;
                if (op_q == OP_STEP && rem != '0) begin
                  phasestep <= 1'b1;
                  state     <= PULSE;
                end else begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= DONE;
                end
              end
              default: ;
            endcase
          end
        end
        DONE:    state <= IDLE;
        default: state <= WAIT_LOCK;
      endcase
    end
  end

endmodule
